// File: rtl/ep2_packet_rr_arbiter_pkg.sv
// Shared ep2 definitions: arbiter FSM states and the select-width helper.
package ep2_packet_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // An index field is at least one bit wide, even for a single port.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ep2_packet_rr_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_priority_pick
    import ep2_packet_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int SEL_WIDTH = clog2_min1(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [SEL_WIDTH-1:0] ptr_i,
    output logic [SEL_WIDTH-1:0] idx_o,
    output logic                 found_o
);

    localparam logic [SEL_WIDTH:0] NP = (SEL_WIDTH + 1)'(NUM_PORTS);

    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] cand;

    // One extra bit on the sum keeps ptr+offset from overflowing before the wrap.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            sum = {1'b0, ptr_i} + (SEL_WIDTH + 1)'(off);
            if (sum >= NP) sum = sum - NP;
            cand = sum[SEL_WIDTH-1:0];
            if (!found_o && req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ep2_packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream inputs, with a per-packet select stream.
module ep2_packet_rr_arbiter
    import ep2_packet_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int VAL_WIDTH      = 16,
    parameter int VAL_KEEP_WIDTH = VAL_WIDTH / 8,
    parameter int IS_STREAM      = 1,
    parameter int SEL_WIDTH      = clog2_min1(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*VAL_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*VAL_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [VAL_WIDTH-1:0]                m_val_axis_tdata,
    output logic [VAL_KEEP_WIDTH-1:0]           m_val_axis_tkeep,
    output logic                                m_val_axis_tlast,
    output logic                                m_val_axis_tvalid,
    input  logic                                m_val_axis_tready,
    output logic [SEL_WIDTH-1:0]                m_sel_axis_tdata,
    output logic                                m_sel_axis_tvalid,
    input  logic                                m_sel_axis_tready
);

    state_e                    state_q, state_d;
    logic [SEL_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]      grant_q, grant_d;
    logic [SEL_WIDTH-1:0]      sel_data_q, sel_data_d;
    logic                      sel_valid_q, sel_valid_d;
    logic [VAL_WIDTH-1:0]      val_data_q, val_data_d;
    logic [VAL_KEEP_WIDTH-1:0] val_keep_q, val_keep_d;
    logic                      val_last_q, val_last_d;
    logic                      val_valid_q, val_valid_d;

    logic [VAL_WIDTH-1:0]      in_data [NUM_PORTS];
    logic [VAL_KEEP_WIDTH-1:0] in_keep [NUM_PORTS];
    logic [SEL_WIDTH-1:0]      pick_idx;
    logic                      pick_found;
    logic                      sel_free, val_free, beat_last;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign in_data[i] = s_axis_tdata[i*VAL_WIDTH +: VAL_WIDTH];
        assign in_keep[i] = s_axis_tkeep[i*VAL_KEEP_WIDTH +: VAL_KEEP_WIDTH];
    end

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req_i   (s_axis_tvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign sel_free  = !sel_valid_q || m_sel_axis_tready;
    assign val_free  = !val_valid_q || m_val_axis_tready;
    // In beat mode every beat closes its own packet.
    assign beat_last = (IS_STREAM != 0) ? s_axis_tlast[grant_q] : 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        sel_data_d    = sel_data_q;
        sel_valid_d   = sel_valid_q && !m_sel_axis_tready;
        val_data_d    = val_data_q;
        val_keep_d    = val_keep_q;
        val_last_d    = val_last_q;
        val_valid_d   = val_valid_q && !m_val_axis_tready;
        s_axis_tready = '0;
        case (state_q)
            ST_IDLE: begin
                // Holding off while a sel word is pending keeps sel and data packet-aligned.
                if (pick_found && sel_free) begin
                    grant_d     = pick_idx;
                    sel_data_d  = pick_idx;
                    sel_valid_d = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_axis_tready[grant_q] = val_free;
                if (val_free && s_axis_tvalid[grant_q]) begin
                    val_data_d  = in_data[grant_q];
                    val_keep_d  = (IS_STREAM != 0) ? in_keep[grant_q] : '1;
                    val_last_d  = beat_last;
                    val_valid_d = 1'b1;
                    if (beat_last) begin
                        rr_ptr_d = (grant_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            sel_data_q  <= '0;
            sel_valid_q <= 1'b0;
            val_data_q  <= '0;
            val_keep_q  <= '0;
            val_last_q  <= 1'b0;
            val_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            sel_data_q  <= sel_data_d;
            sel_valid_q <= sel_valid_d;
            val_data_q  <= val_data_d;
            val_keep_q  <= val_keep_d;
            val_last_q  <= val_last_d;
            val_valid_q <= val_valid_d;
        end
    end

    assign m_val_axis_tdata  = val_data_q;
    assign m_val_axis_tkeep  = val_keep_q;
    assign m_val_axis_tlast  = val_last_q;
    assign m_val_axis_tvalid = val_valid_q;
    assign m_sel_axis_tdata  = sel_data_q;
    assign m_sel_axis_tvalid = sel_valid_q;

endmodule
